uart_rx: RTL and testbench

- 8N1 UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Pairs with the existing uart_tx on the same soc_system link and uses the same runtime baud input and clock-frequency parameter.
- Synchronises the asynchronous serial line and samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe; reports framing errors.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// clocks-per-bit helper used by the UART blocks on the soc_system link.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_RX_START_BIT = 3'd1,
    s_RX_DATA_BITS = 3'd2,
    s_RX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } rx_state_t;

  localparam logic [31:0] DEFAULT_CLKS_PER_BIT = 32'd139;
  localparam int unsigned DATA_BITS            = 8;

  // A zero baud or a quotient below 2 would make the mid-bit point meaningless,
  // so the previous clocks-per-bit value is kept instead.
  function automatic logic [31:0] next_cpb(input logic [31:0] clk_freq,
                                           input logic [31:0] baud,
                                           input logic [31:0] cur);
    logic [31:0] q;
    if (baud == 32'd0) begin
      return cur;
    end
    q = clk_freq / baud;
    return (q < 32'd2) ? cur : q;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line, idling high, with a one-cycle
// pulse marking each high-to-low transition of the synchronised line.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
      fall  <= 1'b0;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
      fall  <= rx_s & ~rx_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime baud selection, mid-bit sampling, a one-cycle
// byte-valid strobe and a one-cycle framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic [31:0] i_BAUD,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [7:0]  o_Rx_Byte,
  output logic        o_Rx_Active,
  output logic        o_Rx_Frame_Err
);

  localparam logic [31:0] CLK_FREQ = 32'(CLK_FREQ_HZ);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t   state;
  logic [31:0] cpb;
  logic [31:0] half;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        armed;
  logic        rx_s;
  logic        fall;

  uart_rx_sync u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .rx    (i_Rx_Serial),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cpb <= DEFAULT_CLKS_PER_BIT;
    end else begin
      cpb <= next_cpb(CLK_FREQ, i_BAUD, cpb);
    end
  end

  assign half = cpb >> 1;

  // Compares use >= so a mid-frame baud drop cannot strand the counter above
  // its terminal value.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= s_IDLE;
      cnt            <= 32'd0;
      idx            <= 3'd0;
      shreg          <= 8'd0;
      armed          <= 1'b0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'd0;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      case (state)
        s_IDLE: begin
          cnt            <= 32'd0;
          idx            <= 3'd0;
          o_Rx_DV        <= 1'b0;
          o_Rx_Frame_Err <= 1'b0;
          // Arming only while the line is high keeps a held break from retriggering.
          if (armed && fall) begin
            state       <= s_RX_START_BIT;
            armed       <= 1'b0;
            o_Rx_Active <= 1'b1;
          end else if (rx_s) begin
            armed <= 1'b1;
          end
        end

        s_RX_START_BIT: begin
          if (cnt >= half - 32'd1) begin
            cnt <= 32'd0;
            if (!rx_s) begin
              state <= s_RX_DATA_BITS;
            end else begin
              state       <= s_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        s_RX_DATA_BITS: begin
          if (cnt >= cpb - 32'd1) begin
            cnt        <= 32'd0;
            shreg[idx] <= rx_s;
            if (idx == LAST_BIT) begin
              idx   <= 3'd0;
              state <= s_RX_STOP_BIT;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        s_RX_STOP_BIT: begin
          if (cnt >= cpb - 32'd1) begin
            cnt   <= 32'd0;
            state <= s_CLEANUP;
            if (rx_s) begin
              o_Rx_Byte <= shreg;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        s_CLEANUP: begin
          state          <= s_IDLE;
          o_Rx_DV        <= 1'b0;
          o_Rx_Frame_Err <= 1'b0;
          o_Rx_Active    <= 1'b0;
        end

        default: begin
          state          <= s_IDLE;
          cnt            <= 32'd0;
          idx            <= 3'd0;
          o_Rx_DV        <= 1'b0;
          o_Rx_Frame_Err <= 1'b0;
          o_Rx_Active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames with a strobe scoreboard,
// plus hand-written reset, glitch, break and latency sequences.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] baud = 32'd1_000_000;
  logic        rx = 1'b1;
  logic        dv;
  logic [7:0]  rbyte;
  logic        active;
  logic        fe;

  uart_rx #(.CLK_FREQ_HZ(16_000_000)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_BAUD         (baud),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (fe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] baud;
    int          bc;
    int          gap;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       tbl[6];
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input int bc);
    rx = v;
    repeat (bc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
    exp_t e;
    e.err = ~stop;
    if (stop) last_good = b;
    e.data = last_good;
    sb_q.push_back(e);
    drive(1'b0, bc);
    for (int i = 0; i < 8; i++) drive(b[i], bc);
    drive(stop, bc);
  endtask

  // Strobe monitor: every DV / frame-error pulse is matched against the scoreboard.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dv || fe) begin
        check("strobe_exclusive", 32'(dv & fe), 32'd0);
        check("strobe_width", 32'(prev), 32'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: dv=%0b err=%0b byte=0x%0h, required no strobe", dv, fe, rbyte);
        end else begin
          e = sb_q.pop_front();
          check("strobe_kind_err", 32'(fe), 32'(e.err));
          check("rx_byte", 32'(rbyte), 32'(e.data));
        end
      end
      prev = dv || fe;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    tbl[0] = '{8'hA5, 1'b1, 32'd1_000_000, 16, 4};
    tbl[1] = '{8'h00, 1'b1, 32'd1_000_000, 16, 0};
    tbl[2] = '{8'hFF, 1'b1, 32'd1_000_000, 16, 0};
    tbl[3] = '{8'h55, 1'b1, 32'd1_000_000, 16, 8};
    tbl[4] = '{8'hC3, 1'b1, 32'd2_000_000, 8, 8};
    tbl[5] = '{8'h5A, 1'b1, 32'd0,         8, 8};

    repeat (3) @(negedge clk);
    check("reset_dv", 32'(dv), 32'd0);
    check("reset_err", 32'(fe), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    check("reset_byte", 32'(rbyte), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (baud != tbl[i].baud) begin
        baud = tbl[i].baud;
        repeat (4) @(negedge clk);
      end
      check("idle_active", 32'(active), 32'd0);
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].bc);
      check("active_after_frame", 32'(active), 32'd0);
      repeat (tbl[i].gap) @(negedge clk);
    end

    // Reset mid-frame, with start-detect latency checked on the way in.
    baud = 32'd1_000_000;
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    check("active_latency_pre", 32'(active), 32'd0);
    @(negedge clk);
    check("active_latency_post", 32'(active), 32'd1);
    repeat (61) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_dv", 32'(dv), 32'd0);
    check("midreset_err", 32'(fe), 32'd0);
    check("midreset_active", 32'(active), 32'd0);
    check("midreset_byte", 32'(rbyte), 32'd0);
    last_good = 8'h00;
    repeat (80) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_active", 32'(active), 32'd0);
    send_frame(8'h3C, 1'b1, 16);
    repeat (8) @(negedge clk);

    // False start: short low glitch.
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= active;
    end
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen |= active;
    end
    check("glitch_active_pulse", 32'(seen), 32'd1);
    check("glitch_active_clear", 32'(active), 32'd0);
    send_frame(8'h81, 1'b1, 16);
    repeat (8) @(negedge clk);

    // Framing error followed by a long break.
    send_frame(8'h12, 1'b0, 16);
    seen = 1'b0;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      seen |= active;
    end
    check("break_quiet", 32'(seen), 32'd0);
    check("break_byte_held", 32'(rbyte), 32'h81);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(8'h34, 1'b1, 16);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    check("final_active", 32'(active), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
